// File: rtl/fifo_pkg.sv
// Shared constants for the flagged FIFO: read-mode selectors and pointer sizing.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Pointer width including the extra wrap bit that separates full from empty.
  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: registered write port, combinational read port.
// Zero read latency; no backpressure here, the caller decides when a slot is written.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered flags, count, sticky errors, flush and optional FWFT.
// Read latency 1 cycle (FWFT=0) or 0 (FWFT=1); writes at full / reads at empty are dropped and flagged.
module sync_fifo_flags import fifo_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = ptr_bits(DEPTH) - 1,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = FWFT_OFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 r_en,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
  localparam logic [CW-1:0] FULL_XOR = {1'b1, {PTR_WIDTH{1'b0}}};

  logic [CW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    wr_sel, rd_sel, cnt_sel;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_q;

  // Next-state pointers and count; flush overrides any accepted transfer.
  always_comb begin
    wr_acc  = w_en & ~full;
    rd_acc  = r_en & ~empty;
    wr_sel  = wr_ptr + CW'(wr_acc);
    rd_sel  = rd_ptr + CW'(rd_acc);
    cnt_sel = count;
    if (wr_acc & ~rd_acc)      cnt_sel = count + CW'(1);
    else if (rd_acc & ~wr_acc) cnt_sel = count - CW'(1);
    if (flush) begin
      wr_sel  = '0;
      rd_sel  = '0;
      cnt_sel = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_sel;
      rd_ptr       <= rd_sel;
      count        <= cnt_sel;
      full         <= (wr_sel ^ rd_sel) == FULL_XOR;
      empty        <= wr_sel == rd_sel;
      almost_full  <= cnt_sel >= AF_C;
      almost_empty <= cnt_sel <= AE_C;
      // A fresh error in the clearing cycle wins over clr_err.
      overflow     <= (overflow  & ~clr_err) | (w_en & full);
      underflow    <= (underflow & ~clr_err) | (r_en & empty);
    end
  end

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PTR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~flush & ~rst),
    .waddr (wr_ptr[PTR_WIDTH-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[PTR_WIDTH-1:0]),
    .rdata (ram_q)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    assign data_out   = ram_q;
    assign data_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;
    logic             dv_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_acc & ~flush;
        if (rd_acc & ~flush) dout_q <= ram_q;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
  end

endmodule
